// File: rtl/fw_fsm_responder.sv
// Firmware-check responder: decrypts the latched signature, returns ChipID then hash, waits for the verdict.
// Latency: start->chipid_rdy 2 cycles, ->hash_rdy ROUNDS+3; no backpressure, the initiator must sample pulses.
module fw_fsm_responder #(
    parameter logic [255:0] KEY            = '0,
    parameter logic [255:0] CHIP_ID        = '0,
    parameter int unsigned  ROUNDS         = 4,
    parameter int unsigned  TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   fw_instruction,
    input  logic [255:0] encrypted_fw_in,
    output logic         fw_chipid_rdy,
    output logic         fw_expected_hash_rdy,
    output logic [255:0] fw_fsm_out,
    output logic         busy,
    output logic         verdict_valid,
    output logic         fw_pass,
    output logic         fw_fail,
    output logic         fw_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        DECRYPT,
        SEND_ID,
        HASH,
        SEND_HASH,
        WAIT_VERDICT
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [255:0] enc_latch;
    logic [255:0] plain;
    logic [255:0] h;
    logic [255:0] hash_nxt;
    logic [7:0]   round;
    logic [31:0]  wait_cnt;
    logic         cmd_start;
    logic         cmd_pass;
    logic         cmd_fail;
    logic         last_round;
    logic         tmo_hit;

    assign cmd_start  = (fw_instruction == 3'b001);
    assign cmd_pass   = (fw_instruction == 3'b100);
    assign cmd_fail   = (fw_instruction == 3'b010);
    assign last_round = (round == 8'(ROUNDS - 1));
    assign hash_nxt   = {h[254:0], h[255]} ^ {248'd0, round};

    // Timeout is measured from the hash_rdy cycle, so the verdict pulse lands TIMEOUT_CYCLES after it.
    assign tmo_hit = ((wait_cnt + 32'd2) >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (cmd_start) state_nxt = DECRYPT;
            DECRYPT:      state_nxt = SEND_ID;
            SEND_ID:      state_nxt = HASH;
            HASH:         if (last_round) state_nxt = SEND_HASH;
            SEND_HASH:    state_nxt = WAIT_VERDICT;
            WAIT_VERDICT: if (cmd_pass || cmd_fail || tmo_hit) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy                 = (state != IDLE);
        fw_chipid_rdy        = (state == SEND_ID);
        fw_expected_hash_rdy = (state == SEND_HASH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_latch     <= '0;
            plain         <= '0;
            h             <= '0;
            round         <= '0;
            wait_cnt      <= '0;
            fw_fsm_out    <= '0;
            verdict_valid <= 1'b0;
            fw_pass       <= 1'b0;
            fw_fail       <= 1'b0;
            fw_timeout    <= 1'b0;
        end else begin
            verdict_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        enc_latch  <= encrypted_fw_in;
                        fw_pass    <= 1'b0;
                        fw_fail    <= 1'b0;
                        fw_timeout <= 1'b0;
                    end
                end
                DECRYPT: begin
                    plain      <= enc_latch ^ KEY;
                    fw_fsm_out <= CHIP_ID;
                end
                SEND_ID: begin
                    h     <= plain;
                    round <= '0;
                end
                HASH: begin
                    h     <= hash_nxt;
                    round <= round + 8'd1;
                    if (last_round) fw_fsm_out <= hash_nxt;
                end
                SEND_HASH: begin
                    wait_cnt <= '0;
                end
                WAIT_VERDICT: begin
                    if (cmd_pass) begin
                        fw_pass       <= 1'b1;
                        verdict_valid <= 1'b1;
                    end else if (cmd_fail) begin
                        fw_fail       <= 1'b1;
                        verdict_valid <= 1'b1;
                    end else if (tmo_hit) begin
                        fw_timeout    <= 1'b1;
                        verdict_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fw_fsm_responder.sv
// Randomized sessions against a spec-level model; a negedge monitor scores every rdy/verdict pulse.
module tb_fw_fsm_responder;

    localparam logic [255:0] KEY     = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a5c3c3c3c3_0f0f0f0ff0f0f0f0;
    localparam logic [255:0] CHIP_ID = 256'hc0ffee00_11223344_55667788_99aabbcc_ddeeff00_13572468_deadbeef_cafef00d;
    localparam int ROUNDS  = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   fw_instruction = 3'b000;
    logic [255:0] encrypted_fw_in = '0;
    logic         fw_chipid_rdy;
    logic         fw_expected_hash_rdy;
    logic [255:0] fw_fsm_out;
    logic         busy;
    logic         verdict_valid;
    logic         fw_pass;
    logic         fw_fail;
    logic         fw_timeout;

    fw_fsm_responder #(
        .KEY(KEY), .CHIP_ID(CHIP_ID), .ROUNDS(ROUNDS), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .fw_instruction(fw_instruction), .encrypted_fw_in(encrypted_fw_in),
        .fw_chipid_rdy(fw_chipid_rdy), .fw_expected_hash_rdy(fw_expected_hash_rdy),
        .fw_fsm_out(fw_fsm_out), .busy(busy), .verdict_valid(verdict_valid),
        .fw_pass(fw_pass), .fw_fail(fw_fail), .fw_timeout(fw_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int           at;
        logic [255:0] val;
    } exp_t;

    exp_t chip_q[$];
    exp_t hash_q[$];
    exp_t verd_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference hash: ROUNDS iterations of rotate-left-by-one then xor with the round number.
    function automatic logic [255:0] ref_hash(input logic [255:0] enc);
        logic [255:0] x;
        x = enc ^ KEY;
        for (int r = 0; r < ROUNDS; r++) x = {x[254:0], x[255]} ^ 256'(r);
        return x;
    endfunction

    function automatic logic [2:0] any_code();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic [2:0] quiet_code();
        logic [2:0] c;
        do c = 3'($urandom_range(0, 7)); while (c == 3'b100 || c == 3'b010);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 pass, 1 fail, 2 timeout, 3 reset in WAIT_VERDICT. d: verdict/reset delay after hash_rdy.
    task automatic session(input int kind, input int d, input logic [255:0] enc);
        int c0;
        int t;
        c0 = cyc;
        t  = c0 + ROUNDS + 3;
        fw_instruction  = 3'b001;
        encrypted_fw_in = enc;
        chip_q.push_back('{c0 + 2, CHIP_ID});
        hash_q.push_back('{t, ref_hash(enc)});
        step();
        while (cyc <= t) begin
            fw_instruction  = any_code();
            encrypted_fw_in = rand256();
            step();
        end
        if (kind == 2) begin
            verd_q.push_back('{t + TIMEOUT, 256'b001});
            while (cyc < t + TIMEOUT) begin
                fw_instruction = quiet_code();
                step();
            end
            fw_instruction = 3'b000;
        end else begin
            while (cyc < t + d) begin
                fw_instruction = quiet_code();
                step();
            end
            if (kind == 3) begin
                rst = 1'b1;
                fw_instruction = 3'b100;
                step();
                rst = 1'b0;
                step();
                check("post_reset_busy", 256'(busy), 256'd0);
                check("post_reset_flags", 256'({verdict_valid, fw_pass, fw_fail, fw_timeout}), 256'd0);
            end else begin
                fw_instruction = (kind == 0) ? 3'b100 : 3'b010;
                verd_q.push_back('{t + d + 1, (kind == 0) ? 256'b100 : 256'b010});
                step();
            end
            fw_instruction = 3'b000;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fw_chipid_rdy && fw_expected_hash_rdy) check("rdy_overlap", 256'd1, 256'd0);
        if (fw_chipid_rdy) begin
            if (chip_q.size() == 0) check("chip_unexpected", 256'd1, 256'd0);
            else begin
                e = chip_q.pop_front();
                check("chip_cycle", 256'(cyc), 256'(e.at));
                check("chip_data", fw_fsm_out, e.val);
                check("chip_flags_cleared", 256'({fw_pass, fw_fail, fw_timeout, busy}), 256'b0001);
            end
        end
        if (fw_expected_hash_rdy) begin
            if (hash_q.size() == 0) check("hash_unexpected", 256'd1, 256'd0);
            else begin
                e = hash_q.pop_front();
                check("hash_cycle", 256'(cyc), 256'(e.at));
                check("hash_data", fw_fsm_out, e.val);
            end
        end
        if (verdict_valid) begin
            if (verd_q.size() == 0) check("verdict_unexpected", 256'd1, 256'd0);
            else begin
                e = verd_q.pop_front();
                check("verdict_cycle", 256'(cyc), 256'(e.at));
                check("verdict_flags", 256'({fw_pass, fw_fail, fw_timeout}), e.val);
                check("verdict_busy", 256'(busy), 256'd0);
            end
        end
    end

    initial begin
        int kind;
        int d;
        rst = 1'b1;
        fw_instruction = 3'b001;
        for (int k = 0; k < 3; k++) begin
            encrypted_fw_in = rand256();
            step();
            check("reset_ctrl", 256'({fw_chipid_rdy, fw_expected_hash_rdy, busy, verdict_valid,
                                      fw_pass, fw_fail, fw_timeout}), 256'd0);
            check("reset_bus", fw_fsm_out, 256'd0);
        end
        rst = 1'b0;
        fw_instruction = 3'b000;
        step();

        session(0, 2, KEY);
        session(1, TIMEOUT - 1, rand256());
        session(2, 0, rand256());
        session(0, 1, rand256());
        session(3, 3, rand256());
        session(0, 5, rand256());

        for (int s = 0; s < 30; s++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                fw_instruction = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b010;
                step();
            end
            kind = $urandom_range(0, 3);
            d = (kind == 2) ? 0 : $urandom_range(1, TIMEOUT - 1);
            session(kind, d, rand256());
        end

        fw_instruction = 3'b000;
        repeat (TIMEOUT + 4) step();
        check("chip_q_drained", 256'(chip_q.size()), 256'd0);
        check("hash_q_drained", 256'(hash_q.size()), 256'd0);
        check("verdict_q_drained", 256'(verd_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
